// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: range-checks CPU byte/half/word requests, drives a synchronous data
// RAM and returns extended load data. Define DMEM_MISALIGN_FAULT_EN to fault misaligned accesses.
module dmem_bus_ctrl #(
  parameter logic [31:0] DATA_RAM_BEGIN = 32'h0000_4000,
  parameter logic [31:0] DATA_RAM_END   = 32'h0000_6000,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [WORD_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [WORD_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_fault_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [WORD_WIDTH-1:0] ram_wdata_o,
  input  logic [WORD_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                  state_q;
  logic                    req_ready_q, rsp_valid_q, rsp_fault_q, ram_we_q;
  logic [WORD_WIDTH-1:0]   rsp_rdata_q, ram_wdata_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [3:0]              ram_be_q;
  logic [2:0]              cnt_q;
  logic                    we_q, unsigned_q;
  logic [1:0]              size_q, lane_q;

  logic [2:0]              size_bytes;
  logic [32:0]             req_end;
  logic                    req_illegal;
  logic [31:0]             addr_al;
  logic [ADDR_WIDTH-1:0]   ram_addr_d;
  logic [3:0]              ram_be_d;
  logic [WORD_WIDTH-1:0]   ram_wdata_d;

  // Request decode: legality, force-aligned address, lane enables and replicated store data.
  always_comb begin
    unique case (req_size_i)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      2'b10:   size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
    req_end     = {1'b0, req_addr_i} + 33'(size_bytes);
    req_illegal = (req_size_i == 2'b11) || (req_addr_i < DATA_RAM_BEGIN) ||
                  (req_addr_i >= DATA_RAM_END) || (req_end > {1'b0, DATA_RAM_END});
`ifdef DMEM_MISALIGN_FAULT_EN
    if (((req_size_i == 2'b01) && req_addr_i[0]) ||
        ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))) begin
      req_illegal = 1'b1;
    end
`endif
    addr_al = req_addr_i;
    if (req_size_i == 2'b01) addr_al[0] = 1'b0;
    if (req_size_i == 2'b10) addr_al[1:0] = 2'b00;
    ram_addr_d = ADDR_WIDTH'((addr_al - DATA_RAM_BEGIN) >> 2);

    unique case (req_size_i)
      2'b00: begin
        ram_be_d    = 4'b0001 << addr_al[1:0];
        ram_wdata_d = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        ram_be_d    = addr_al[1] ? 4'b1100 : 4'b0011;
        ram_wdata_d = {2{req_wdata_i[15:0]}};
      end
      default: begin
        ram_be_d    = 4'b1111;
        ram_wdata_d = req_wdata_i;
      end
    endcase
  end

  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [WORD_WIDTH-1:0] load_ext;

  always_comb begin
    rd_byte = 8'(ram_rdata_i >> {lane_q, 3'b000});
    rd_half = lane_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{~unsigned_q & rd_half[15]}}, rd_half};
      default: load_ext = ram_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (req_illegal) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
            end else begin
              state_q     <= StIssue;
              ram_addr_q  <= ram_addr_d;
              ram_be_q    <= ram_be_d;
              ram_we_q    <= req_we_i;
              ram_wdata_q <= req_we_i ? ram_wdata_d : '0;
              we_q        <= req_we_i;
              unsigned_q  <= req_unsigned_i;
              size_q      <= req_size_i;
              lane_q      <= addr_al[1:0];
            end
          end
        end
        StIssue: begin
          ram_we_q <= 1'b0;
          if (we_q) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= StWait;
            cnt_q   <= 3'(READ_LATENCY);
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 3'd1;
          // The counter reaches zero on this edge: RAM data is valid now.
          if (cnt_q == 3'd1) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_ext;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_fault_o = rsp_fault_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign ram_we_o    = ram_we_q;
  assign ram_be_o    = ram_be_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Data-memory bus controller between the CPU load/store stage and the synchronous data RAM window 0x0000_4000–0x0000_5FFF.
- Accepts one byte/half/word request at a time and range-checks it against the data-RAM window.
- Converts the byte address to a RAM word index, generates byte enables and lane-replicated write data.
- Returns loads sign- or zero-extended, with a fault flag for illegal accesses.

Parameters:
- DATA_RAM_BEGIN, 32'h0000_4000, first byte address of the data RAM (inclusive).
- DATA_RAM_END, 32'h0000_6000, end byte address of the data RAM (exclusive).
- WORD_WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 11, RAM word-index width; equals clog2((DATA_RAM_END-DATA_RAM_BEGIN)/4).
- READ_LATENCY, 1, RAM clock edges from address sample to valid ram_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  request rejected, no RAM access performed.
- ram_addr  out  ADDR_WIDTH  RAM word index.
- ram_we  out  1  RAM write strobe.
- ram_be  out  4  RAM byte enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state = IDLE, req_ready = 0 while rst is high, rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0, ram_we = 0, ram_be = 0, ram_addr = 0, ram_wdata = 0.
- All outputs are registered. req_ready = (state == IDLE).
- Handshake: a request is accepted at the rising edge where req_valid && req_ready. Request fields are sampled only at that edge.
- No backpressure on responses; the CPU must take rsp_valid in the cycle it is high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, on accept:
  - Illegal request (size 11, address outside [BEGIN, END), or address + size-bytes crossing END) → RESP with rsp_fault = 1. No RAM strobe.
  - Legal request → ISSUE, with ram_addr = (req_addr - DATA_RAM_BEGIN) >> 2 truncated to ADDR_WIDTH bits.
  - Legal store also sets ram_we = 1 and drives ram_be / ram_wdata.
- ISSUE (exactly 1 cycle, RAM samples at its end):
  - ram_we returns to 0 on exit.
  - Store → RESP.
  - Load → WAIT with a counter loaded to READ_LATENCY.
- WAIT: decrement the counter each cycle. At the edge where it reaches 0, capture and format ram_rdata into rsp_rdata and go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_fault and rsp_rdata clear to 0 on leaving RESP.
- Latency, counting the accept edge as E0:
  - Fault response: cycle E0–E1.
  - Store: ram_we high E0–E1, response E1–E2.
  - Load: response in cycle (E1 + READ_LATENCY)–(E2 + READ_LATENCY); e.g. E2–E3 for READ_LATENCY = 1.
- Byte lanes, with lane = addr[1:0]:
  - Byte: ram_be = 4'b0001 << lane; wdata byte replicated to all four lanes.
  - Half: ram_be = 0011 when addr[1] = 0, 1100 when addr[1] = 1; half replicated to both halves.
  - Word: ram_be = 1111.
- Load extract: select the byte or half by lane, then sign- or zero-extend per the latched unsigned flag. Word loads pass through unchanged.
- Boundaries:
  - Addresses DATA_RAM_END-1 (byte) and DATA_RAM_END-4 (word) are legal. DATA_RAM_END is a fault, as is BEGIN-1.
  - Requests arriving while not in IDLE are ignored; the CPU must hold them.
  - Back-to-back requests: the next accept occurs no earlier than the cycle after RESP.
  - rst asserted mid-operation: immediate return to reset values. ram_we drops asynchronously. No response is ever issued for the aborted request.

Optional Feature:
- Macro: DMEM_MISALIGN_FAULT_EN.
- Defined: half with addr[0] = 1, or word with addr[1:0] != 0, is illegal → fault response. No RAM access.
- Undefined: misaligned requests are force-aligned before the access.
  - Half uses addr[0] = 0; word uses addr[1:0] = 00.
  - Byte-enable and extract logic use the aligned address. No fault.

Test Plan:
- Store word 0xDEADBEEF @0x4000, then load word @0x4000 → ram_we pulse with ram_addr = 0 and ram_be = 1111; load rsp_rdata = 0xDEADBEEF, rsp_valid at E2 (READ_LATENCY = 1), rsp_fault = 0.
- Store byte 0x80 @0x4007, then load signed byte @0x4007 and unsigned byte @0x4007:
  - Store: ram_addr = 1, ram_be = 1000, ram_wdata = 0x80808080.
  - Loads return 0xFFFFFF80 and 0x00000080.
- Load half @0x5FFE returns stored data with ram_addr = 0x7FF, ram_be = 1100; load byte @0x6000 and @0x3FFF → rsp_fault = 1, rsp_valid in cycle E0–E1, ram_we never asserted.
- Load half @0x4001:
  - DMEM_MISALIGN_FAULT_EN defined: rsp_fault = 1.
  - Undefined: returns half @0x4000, fault = 0.
- Assert rst in ISSUE of a store and in WAIT of a load → all outputs 0 within the same cycle, no rsp_valid afterwards, req_ready = 1 one cycle after rst falls.
- READ_LATENCY = 3, back-to-back loads with req_valid held → req_ready low from accept until after RESP; each rsp_valid arrives 4 cycles after its accept edge.
